// File: rtl/tetris_move_if.sv
// Signal bundle for the falling-piece move controller: player requests,
// the collision-checker handshake and the committed piece position.
interface tetris_move_if;
  logic       enable;
  logic       left_req;
  logic       right_req;
  logic       drop_req;
  logic       spawn;
  logic       chk_req;
  logic [4:0] chk_x;
  logic [4:0] chk_y;
  logic       chk_done;
  logic       chk_free;
  logic [4:0] pos_x;
  logic [4:0] pos_y;
  logic       moved;
  logic       locked;
  logic       busy;

  // master: the move controller, which issues candidate positions to the checker
  modport master (
    input  enable, left_req, right_req, drop_req, spawn, chk_done, chk_free,
    output chk_req, chk_x, chk_y, pos_x, pos_y, moved, locked, busy
  );

  modport slave (
    output enable, left_req, right_req, drop_req, spawn, chk_done, chk_free,
    input  chk_req, chk_x, chk_y, pos_x, pos_y, moved, locked, busy
  );
endinterface

// File: rtl/tetris_move_ctrl.sv
// Falling-piece move sequencer: coalesces player and gravity requests, checks board
// limits, runs the collision-check handshake and owns the committed piece position.
module tetris_move_ctrl #(
  parameter int BOARD_W  = 10,
  parameter int BOARD_H  = 20,
  parameter int SPAWN_X  = 5,
  parameter int SPAWN_Y  = 0,
  parameter int GRAV_DIV = 25000000
) (
  input  logic          clk,
  input  logic          reset,
  tetris_move_if.master bus
);
  localparam logic [4:0]  X_MAX     = 5'(BOARD_W - 1);
  localparam logic [4:0]  Y_MAX     = 5'(BOARD_H - 1);
  localparam logic [4:0]  X_SPAWN   = 5'(SPAWN_X);
  localparam logic [4:0]  Y_SPAWN   = 5'(SPAWN_Y);
  localparam logic [31:0] GRAV_LAST = 32'(GRAV_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, LOCKED} state_t;
  typedef enum logic [1:0] {MV_DOWN, MV_LEFT, MV_RIGHT} move_t;

  state_t      state_q, state_d;
  move_t       move_q, move_d;
  logic [31:0] grav_cnt_q, grav_cnt_d;
  logic        pend_down_q, pend_down_d;
  logic        pend_left_q, pend_left_d;
  logic        pend_right_q, pend_right_d;
  logic [4:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [4:0]  chk_x_q, chk_x_d, chk_y_q, chk_y_d;
  logic        chk_req_q, chk_req_d;
  logic        moved_q, moved_d;
  logic        locked_q, locked_d;
  logic        busy_q, busy_d;
  logic        grav_tick;
  logic        land;
  logic        clr_served;

  always_comb begin
    state_d      = state_q;
    move_d       = move_q;
    grav_cnt_d   = grav_cnt_q;
    pend_down_d  = pend_down_q;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    chk_x_d      = chk_x_q;
    chk_y_d      = chk_y_q;
    chk_req_d    = 1'b0;
    moved_d      = 1'b0;
    locked_d     = 1'b0;
    grav_tick    = 1'b0;
    land         = 1'b0;
    clr_served   = 1'b0;

    if (bus.enable && state_q != LOCKED) begin
      if (grav_cnt_q == GRAV_LAST) begin
        grav_cnt_d = '0;
        grav_tick  = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          if (pend_down_q) begin
            if (pos_y_q == Y_MAX) begin
              land = 1'b1;
            end else begin
              chk_x_d   = pos_x_q;
              chk_y_d   = pos_y_q + 5'd1;
              move_d    = MV_DOWN;
              chk_req_d = 1'b1;
              state_d   = WAIT;
            end
          end else if (pend_left_q) begin
            if (pos_x_q == 5'd0) begin
              pend_left_d = 1'b0;
            end else begin
              chk_x_d   = pos_x_q - 5'd1;
              chk_y_d   = pos_y_q;
              move_d    = MV_LEFT;
              chk_req_d = 1'b1;
              state_d   = WAIT;
            end
          end else if (pend_right_q) begin
            if (pos_x_q == X_MAX) begin
              pend_right_d = 1'b0;
            end else begin
              chk_x_d   = pos_x_q + 5'd1;
              chk_y_d   = pos_y_q;
              move_d    = MV_RIGHT;
              chk_req_d = 1'b1;
              state_d   = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (bus.chk_done) begin
          state_d = IDLE;
          if (bus.chk_free) begin
            pos_x_d    = chk_x_q;
            pos_y_d    = chk_y_q;
            moved_d    = 1'b1;
            clr_served = 1'b1;
            // a committed step down restarts the gravity interval from zero
            if (move_q == MV_DOWN) begin
              grav_cnt_d = '0;
              grav_tick  = 1'b0;
            end
          end else if (move_q == MV_DOWN) begin
            land = 1'b1;
          end else begin
            clr_served = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (clr_served) begin
      case (move_q)
        MV_DOWN: pend_down_d  = 1'b0;
        MV_LEFT: pend_left_d  = 1'b0;
        default: pend_right_d = 1'b0;
      endcase
    end

    if (land) begin
      pend_down_d  = 1'b0;
      pend_left_d  = 1'b0;
      pend_right_d = 1'b0;
      locked_d     = 1'b1;
      grav_cnt_d   = '0;
      state_d      = LOCKED;
    end else if (state_q != LOCKED) begin
      // new requests are applied after the served flag is cleared, so they survive
      if (bus.left_req && !bus.right_req) begin
        pend_left_d  = 1'b1;
        pend_right_d = 1'b0;
      end
      if (bus.right_req && !bus.left_req) begin
        pend_right_d = 1'b1;
        pend_left_d  = 1'b0;
      end
      if (bus.drop_req || grav_tick) begin
        pend_down_d = 1'b1;
      end
    end

    if (bus.spawn) begin
      state_d      = IDLE;
      pos_x_d      = X_SPAWN;
      pos_y_d      = Y_SPAWN;
      chk_x_d      = X_SPAWN;
      chk_y_d      = Y_SPAWN;
      pend_down_d  = 1'b0;
      pend_left_d  = 1'b0;
      pend_right_d = 1'b0;
      grav_cnt_d   = '0;
      chk_req_d    = 1'b0;
      moved_d      = 1'b0;
      locked_d     = 1'b0;
    end

    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      move_q       <= MV_DOWN;
      grav_cnt_q   <= '0;
      pend_down_q  <= 1'b0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      pos_x_q      <= X_SPAWN;
      pos_y_q      <= Y_SPAWN;
      chk_x_q      <= X_SPAWN;
      chk_y_q      <= Y_SPAWN;
      chk_req_q    <= 1'b0;
      moved_q      <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_q       <= move_d;
      grav_cnt_q   <= grav_cnt_d;
      pend_down_q  <= pend_down_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      chk_x_q      <= chk_x_d;
      chk_y_q      <= chk_y_d;
      chk_req_q    <= chk_req_d;
      moved_q      <= moved_d;
      locked_q     <= locked_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.chk_req = chk_req_q;
  assign bus.chk_x   = chk_x_q;
  assign bus.chk_y   = chk_y_q;
  assign bus.pos_x   = pos_x_q;
  assign bus.pos_y   = pos_y_q;
  assign bus.moved   = moved_q;
  assign bus.locked  = locked_q;
  assign bus.busy    = busy_q;
endmodule

// File: doc/tetris_move_ctrl.md
Name: tetris_move_ctrl

Overview:
- Sequences all moves of the falling piece: user left/right/drop pulses and an internal gravity timer.
- Arbitrates between these requesters and checks board limits.
- Runs a request/done handshake with the playfield collision checker before committing a new (x,y).
- Owns the authoritative piece position and signals lock-down when a downward move is blocked.

Parameters:
- BOARD_W, 10, playfield width in cells; legal x is 0..BOARD_W-1.
- BOARD_H, 20, playfield height in cells; legal y is 0..BOARD_H-1.
- SPAWN_X, 5, x loaded at reset and on spawn.
- SPAWN_Y, 0, y loaded at reset and on spawn.
- GRAV_DIV, 25000000, clk cycles per gravity step; minimum 2; 32-bit counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  game running; low pauses gravity and dispatch.
- left_req  in  1  one-cycle pulse, move left.
- right_req  in  1  one-cycle pulse, move right.
- drop_req  in  1  one-cycle pulse, soft drop one row.
- spawn  in  1  one-cycle pulse, new piece at spawn position.
- chk_req  out  1  one-cycle pulse, candidate position valid for collision check.
- chk_x  out  5  candidate x; stable from chk_req until chk_done.
- chk_y  out  5  candidate y; stable from chk_req until chk_done.
- chk_done  in  1  checker result valid.
- chk_free  in  1  qualifies chk_done; 1 means candidate cells are free.
- pos_x  out  5  committed piece x.
- pos_y  out  5  committed piece y.
- moved  out  1  one-cycle pulse on each committed move.
- locked  out  1  one-cycle pulse when the piece lands.
- busy  out  1  high in WAIT.

Behaviour:

Reset (asynchronous):
- Outputs: pos=(SPAWN_X,SPAWN_Y), chk_x/chk_y=(SPAWN_X,SPAWN_Y), chk_req=moved=locked=busy=0.
- Internal: state=IDLE, gravity counter=0, all pending flags cleared.

Pending flags (set on the clock edge a request is sampled; coalescing, never counted):
- pend_down is set by drop_req or by gravity expiry.
- pend_left is set by left_req; pend_right is set by right_req.
- left_req and right_req high in the same cycle: both ignored.
- A new left_req clears pend_right, and a new right_req clears pend_left.

Gravity:
- Counter increments while enable=1 and state!=LOCKED.
- At GRAV_DIV-1 it wraps to 0 and sets pend_down.
- A committed down move clears the counter to 0, so a soft drop restarts the gravity interval.

IDLE state (dispatch only when enable=1):
- Priority is down > left > right.
- Left with pos_x==0: clear pend_left, stay IDLE, no check issued.
- Right with pos_x==BOARD_W-1: clear pend_right, stay IDLE, no check issued.
- Down with pos_y==BOARD_H-1: clear all pending, pulse locked, go to LOCKED; no check issued.
- Otherwise: load candidate (x-1 / x+1 / y+1), pulse chk_req, go to WAIT.

WAIT state:
- chk_done is honoured in any WAIT cycle, including the cycle chk_req is high.
- chk_done with chk_free=1: commit candidate to pos, pulse moved, clear the served flag, go to IDLE.
- chk_done with chk_free=0 on a left/right move: clear the served flag, pos unchanged, go to IDLE.
- chk_done with chk_free=0 on a down move: clear all pending, pulse locked, go to LOCKED.
- enable=0 does not abort WAIT.
- Requests arriving during WAIT only update pending flags.

LOCKED state:
- Requests are ignored, and the gravity counter is held at 0.

spawn (any state, highest precedence):
- pos and chk_x/chk_y set to (SPAWN_X,SPAWN_Y), pending cleared, counter cleared, state=IDLE.
- A chk_done in the same cycle is discarded, and no moved or locked pulse is generated.

Latency:
- A request sampled at edge k gives chk_req high after edge k+1.
- If chk_done returns in that same cycle, pos and moved update at edge k+2.
- Arithmetic: 5-bit unsigned. Pre-checks guarantee no wrap-around.

Test Plan:
- Reset mid-WAIT -> pos=(5,0), chk_req=0, busy=0 immediately; no moved pulse after release.
- left_req at pos (5,0), checker replies chk_done=1, chk_free=1 on the chk_req cycle -> chk_x=4, pos_x=4 two edges after request, moved pulse of exactly 1 cycle.
- Left at x=0, and right at x=9 -> no chk_req, pos unchanged, pend cleared.
- drop_req and right_req in the same cycle at (5,3), both free -> down served first (pos_y=4), then right (pos_x=6); two moved pulses.
- GRAV_DIV=4, enable=1, checker always free -> pos_y increments every 4 cycles plus handshake; at y=19, the next gravity step pulses locked with no chk_req; spawn returns pos to (5,0).
- Down candidate with chk_free=0 at y=7 -> locked pulse, pos_y stays 7; left_req in LOCKED ignored; enable=0 freezes the counter with no dispatch.
